led_sequence_driver: RTL and testbench

Timed LED pattern generator driving the four Go Board LEDs from single-cycle command pulses, such as those produced by the switch edge detectors. It is the output end of the switch-to-LED path. Upstream logic issues a start pulse with a mode and a step count. The block then plays a blink, chase, count or ping-pong sequence at a fixed step rate and reports busy and completion.

---
 rtl/led_sequence_driver.sv | 156 +++++++++++++++
 tb/tb_led_sequence_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_driver.sv
// led_sequence_driver
// Plays a timed LED pattern (chase, blink-all, binary count, ping-pong) on the
// four Go Board LEDs after a single-cycle start pulse. It reports progress with
// a busy flag and signals normal completion with a one-cycle done pulse.
//
// Ports:
//   i_Clk     system clock, rising edge
//   i_Rst_L   asynchronous active-low reset
//   i_Start   start request, honoured only in IDLE with i_Steps != 0
//   i_Stop    abort request, honoured only in RUN
//   i_Mode    pattern select captured with i_Start
//             (0 chase, 1 blink-all, 2 count, 3 ping-pong)
//   i_Steps   number of steps to play, captured with i_Start
//   o_LED     registered LED drive, bit 0 = LED 1
//   o_Busy    registered, high while a pattern is playing
//   o_Done    registered, one-cycle pulse on normal completion
module led_sequence_driver #(
  parameter int CLKS_PER_STEP = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Stop,
  input  logic [1:0] i_Mode,
  input  logic [7:0] i_Steps,
  output logic [3:0] o_LED,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int TIMER_W = $clog2(CLKS_PER_STEP);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         step_q, step_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         steps_q, steps_d;
  logic [3:0]         led_d;
  logic               busy_d;
  logic               done_d;

  // LED image for a given mode and 0-based step index.
  function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [7:0] k);
    logic [7:0] phase;
    logic [3:0] led;
    led = 4'b0000;
    case (mode)
      2'd0: led = 4'b0001 << k[1:0];
      2'd1: led = k[0] ? 4'b0000 : 4'b1111;
      2'd2: led = k[3:0] + 4'd1;
      default: begin
        // Ping-pong bounces 0,1,2,3,2,1 so it repeats every six steps.
        phase = k % 8'd6;
        case (phase)
          8'd0:    led = 4'b0001;
          8'd1:    led = 4'b0010;
          8'd2:    led = 4'b0100;
          8'd3:    led = 4'b1000;
          8'd4:    led = 4'b0100;
          default: led = 4'b0010;
        endcase
      end
    endcase
    return led;
  endfunction

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      timer_q <= '0;
      step_q  <= '0;
      mode_q  <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = step_q;
    mode_d  = mode_q;
    steps_d = steps_q;
    case (state_q)
      IDLE: begin
        if (i_Start && (i_Steps != 8'd0)) begin
          state_d = RUN;
          mode_d  = i_Mode;
          steps_d = i_Steps;
          timer_d = '0;
          step_d  = '0;
        end
      end
      RUN: begin
        // Abort wins over a terminal count in the same cycle.
        if (i_Stop) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          if (step_q == steps_q - 8'd1) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + 8'd1;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic, evaluated on the next state so the registered outputs line
  // up with the state they describe.
  always_comb begin
    led_d  = 4'b0000;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      RUN: begin
        led_d  = pattern(mode_d, step_d);
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LED  <= 4'b0000;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
    end else begin
      o_LED  <= led_d;
      o_Busy <= busy_d;
      o_Done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_sequence_driver.sv
module tb_led_sequence_driver;

  localparam int CPS = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] steps;
  logic [3:0] led;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] steps;
    logic [71:0] leds;   // nibble k holds expected LED for step k
  } vec_t;

  vec_t vecs[4];

  led_sequence_driver #(.CLKS_PER_STEP(CPS)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Start (start),
    .i_Stop  (stop),
    .i_Mode  (mode),
    .i_Steps (steps),
    .o_LED   (led),
    .o_Busy  (busy),
    .o_Done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, ".led"},  {4'b0, led}, 8'h00);
    check({name, ".busy"}, {7'b0, busy}, 8'h00);
    check({name, ".done"}, {7'b0, done}, 8'h00);
  endtask

  // Starts a run in the current cycle and checks every cycle through the
  // cycle after the done pulse, where a new start may be issued at once.
  task automatic run_pattern(input vec_t v);
    mode  = v.mode;
    steps = v.steps;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(v.steps); k++) begin
      for (int c = 0; c < CPS; c++) begin
        check({v.name, ".led"},  {4'b0, led}, {4'b0, v.leds[k*4 +: 4]});
        check({v.name, ".busy"}, {7'b0, busy}, 8'h01);
        check({v.name, ".done"}, {7'b0, done}, 8'h00);
        tick();
      end
    end
    check({v.name, ".done_pulse"}, {7'b0, done}, 8'h01);
    check({v.name, ".done_busy"},  {7'b0, busy}, 8'h00);
    check({v.name, ".done_led"},   {4'b0, led}, 8'h00);
    tick();
    check_idle({v.name, ".after"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'd0;
    steps = 8'd0;
    rst_n = 1'b1;

    vecs[0] = '{name: "chase6",  mode: 2'd0, steps: 8'd6,  leds: 72'h218421};
    vecs[1] = '{name: "count17", mode: 2'd2, steps: 8'd17, leds: 72'h10FEDCBA987654321};
    vecs[2] = '{name: "ping8",   mode: 2'd3, steps: 8'd8,  leds: 72'h21248421};
    vecs[3] = '{name: "blink3",  mode: 2'd1, steps: 8'd3,  leds: 72'hF0F};

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Zero-step request is ignored
    mode  = 2'd1;
    steps = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("zero_steps");
      tick();
    end

    // Table runs back to back: each start lands on the cycle after done
    for (int i = 0; i < 4; i++) run_pattern(vecs[i]);

    // Start during RUN is ignored
    mode  = 2'd0;
    steps = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("retrig.c1", {4'b0, led}, 8'h01);
    tick();
    tick();
    mode  = 2'd1;
    steps = 8'd9;
    start = 1'b1;
    check("retrig.c3", {4'b0, led}, 8'h01);
    tick();
    start = 1'b0;
    check("retrig.c4", {4'b0, led}, 8'h01);
    tick();
    check("retrig.c5", {4'b0, led}, 8'h02);
    for (int i = 0; i < 4; i++) tick();
    check("retrig.done", {7'b0, done}, 8'h01);
    tick();
    check_idle("retrig.after");

    // Stop on the terminal count of step 2
    mode  = 2'd0;
    steps = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("stop.c12_led",  {4'b0, led}, 8'h04);
    check("stop.c12_busy", {7'b0, busy}, 8'h01);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop.c13");
    for (int i = 0; i < 12; i++) begin
      tick();
      check({"stop.no_done"}, {7'b0, done}, 8'h00);
      check({"stop.no_busy"}, {7'b0, busy}, 8'h00);
    end

    // Asynchronous reset mid-run at step 2
    mode  = 2'd2;
    steps = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("areset.step2", {4'b0, led}, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check_idle("areset.immediate");
    tick();
    check_idle("areset.held");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle("areset.stays_idle");
    end

    // Recovery after reset
    run_pattern(vecs[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
